// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu : RV32I load/store unit, one data-memory transaction at a time.
//
// Takes the ALU effective address and rs2, runs a single req/gnt/rvalid bus
// transaction and hands the extended load data (or store completion) back to
// writeback with a one-cycle lsu_done pulse.
//
// Ports
//   clk, rst_n            core clock, synchronous active-low reset
//   lsu_valid/lsu_ready   request handshake (ready only in IDLE)
//   lsu_we, lsu_funct3    store/load select, RV32I width/sign encoding
//   lsu_addr, lsu_wdata   effective address, store data
//   lsu_done              one-cycle completion pulse
//   lsu_rdata, lsu_err    result and error flag, held until the next done
//   mem_req/we/addr/wstrb/wdata   bus request (held stable until mem_gnt)
//   mem_gnt, mem_rvalid, mem_rdata  bus response
//
// Parameters
//   TIMEOUT_CYCLES  cycles allowed in REQ+WAIT before a bus-error abort,
//                   0 disables the timeout.
//
// Build option
//   LSU_MISALIGN_TRAP_EN  when defined, misaligned halfword/word accesses
//                         finish with err=1 without touching the bus.
// ---------------------------------------------------------------------------
module lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic        lsu_we,
    input  logic [2:0]  lsu_funct3,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;

    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        lsu_done_q, lsu_done_d;
    logic [31:0] lsu_rdata_q, lsu_rdata_d;
    logic        lsu_err_q, lsu_err_d;

    logic        illegal;
    logic        misalign;
    logic        tmo;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [31:0] ld_data;

    // Picks the addressed byte/half out of the bus word and extends it.
    function automatic logic [31:0] extract(input logic [2:0]  f3,
                                            input logic [1:0]  off,
                                            input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{off, 3'b000} +: 8];
        h = off[1] ? d[31:16] : d[15:0];
        case (f3)
            3'd0:    extract = {{24{b[7]}}, b};
            3'd4:    extract = {24'd0, b};
            3'd1:    extract = {{16{h[15]}}, h};
            3'd5:    extract = {16'd0, h};
            default: extract = d;
        endcase
    endfunction

    always_comb begin
        illegal = lsu_we ? (lsu_funct3 > 3'd2)
                         : (lsu_funct3 == 3'd3 || lsu_funct3 == 3'd6 || lsu_funct3 == 3'd7);
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = ((lsu_funct3[1:0] == 2'd1) && lsu_addr[0]) ||
                   ((lsu_funct3[1:0] == 2'd2) && (lsu_addr[1:0] != 2'd0));
`else
        // Low address bits the access size cannot use are simply dropped.
        misalign = 1'b0;
`endif
        case (lsu_funct3[1:0])
            2'd0: begin
                st_strb = 4'b0001 << lsu_addr[1:0];
                st_data = {4{lsu_wdata[7:0]}};
            end
            2'd1: begin
                st_strb = lsu_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{lsu_wdata[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = lsu_wdata;
            end
        endcase
        ld_data = extract(funct3_q, off_q, mem_rdata);
        // Counter spans REQ+WAIT; this is the last allowed cycle.
        tmo = (TIMEOUT_CYCLES != 0) && ((cnt_q + 32'd1) == TIMEOUT_CYCLES);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        lsu_done_d  = 1'b0;
        lsu_rdata_d = lsu_rdata_q;
        lsu_err_d   = lsu_err_q;

        case (state_q)
            S_IDLE: begin
                if (lsu_valid) begin
                    funct3_d = lsu_funct3;
                    off_d    = lsu_addr[1:0];
                    if (illegal || misalign) begin
                        state_d     = S_DONE;
                        lsu_done_d  = 1'b1;
                        lsu_err_d   = 1'b1;
                        lsu_rdata_d = 32'd0;
                    end else begin
                        state_d     = S_REQ;
                        cnt_d       = 32'd0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = lsu_we;
                        mem_addr_d  = {lsu_addr[31:2], 2'b00};
                        mem_wstrb_d = lsu_we ? st_strb : 4'd0;
                        mem_wdata_d = lsu_we ? st_data : 32'd0;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 32'd1;
                // A grant in the final cycle still wins over the timeout.
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    if (mem_we_q) begin
                        state_d     = S_DONE;
                        lsu_done_d  = 1'b1;
                        lsu_err_d   = 1'b0;
                        lsu_rdata_d = 32'd0;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (tmo) begin
                    mem_req_d   = 1'b0;
                    state_d     = S_DONE;
                    lsu_done_d  = 1'b1;
                    lsu_err_d   = 1'b1;
                    lsu_rdata_d = 32'd0;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 32'd1;
                if (mem_rvalid) begin
                    state_d     = S_DONE;
                    lsu_done_d  = 1'b1;
                    lsu_err_d   = 1'b0;
                    lsu_rdata_d = ld_data;
                end else if (tmo) begin
                    state_d     = S_DONE;
                    lsu_done_d  = 1'b1;
                    lsu_err_d   = 1'b1;
                    lsu_rdata_d = 32'd0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 32'd0;
            funct3_q    <= 3'd0;
            off_q       <= 2'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wstrb_q <= 4'd0;
            mem_wdata_q <= 32'd0;
            lsu_done_q  <= 1'b0;
            lsu_rdata_q <= 32'd0;
            lsu_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
            lsu_done_q  <= lsu_done_d;
            lsu_rdata_q <= lsu_rdata_d;
            lsu_err_q   <= lsu_err_d;
        end
    end

    assign lsu_ready = (state_q == S_IDLE);
    assign lsu_done  = lsu_done_q;
    assign lsu_rdata = lsu_rdata_q;
    assign lsu_err   = lsu_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsu_valid;
    logic        lsu_ready;
    logic        lsu_we;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        lsu_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_we(lsu_we),
        .lsu_funct3(lsu_funct3), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; on return the capture edge has passed.
    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        lsu_valid  = 1'b1;
        lsu_we     = we;
        lsu_funct3 = f3;
        lsu_addr   = a;
        lsu_wdata  = d;
        step();
        lsu_valid  = 1'b0;
    endtask

    // Load with gnt in the first REQ cycle and rvalid in the next one.
    // lat counts cycles from the valid cycle to the observed done (-1: none).
    task automatic load_txn(input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, output logic [31:0] rd,
                            output logic e, output int lat,
                            output logic [31:0] a_seen, output logic [3:0] s_seen);
        issue(1'b0, f3, a, 32'd0);
        lat    = 1;
        a_seen = mem_addr;
        s_seen = mem_wstrb;
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        lat++;
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        lat++;
        while (!lsu_done && lat < 20) begin
            step();
            lat++;
        end
        if (!lsu_done) lat = -1;
        rd = lsu_rdata;
        e  = lsu_err;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", lsu_ready); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
        checks++; if (lsu_done !== 1'b0 || lsu_err !== 1'b0) begin errors++; $display("FAIL reset_done_err got %b%b exp 00", lsu_done, lsu_err); end
        checks++; if (lsu_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_data got %h %h %h exp zeros", lsu_rdata, mem_addr, mem_wdata); end
        checks++; if (mem_wstrb !== 4'h0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_strb_we got %h %b exp 0 0", mem_wstrb, mem_we); end
    endtask

    task automatic test_store_word();
        issue(1'b1, 3'd2, 32'h0000_0104, 32'hDEAD_BEEF);
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL sw_req got %b%b exp 11", mem_req, mem_we); end
        checks++; if (mem_addr !== 32'h104) begin errors++; $display("FAIL sw_addr got %h exp 00000104", mem_addr); end
        checks++; if (mem_wstrb !== 4'b1111 || mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_strb_data got %b %h exp 1111 deadbeef", mem_wstrb, mem_wdata); end
        checks++; if (lsu_ready !== 1'b0) begin errors++; $display("FAIL sw_busy got %b exp 0", lsu_ready); end
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        checks++; if (lsu_done !== 1'b1 || lsu_err !== 1'b0) begin errors++; $display("FAIL sw_done_lat2 got %b%b exp 10", lsu_done, lsu_err); end
        checks++; if (mem_req !== 1'b0 || lsu_rdata !== 32'h0) begin errors++; $display("FAIL sw_after got %b %h exp 0 0", mem_req, lsu_rdata); end
        step();
        checks++; if (lsu_done !== 1'b0 || lsu_ready !== 1'b1) begin errors++; $display("FAIL sw_pulse got %b%b exp 01", lsu_done, lsu_ready); end
    endtask

    task automatic test_store_lanes();
        issue(1'b1, 3'd0, 32'h0000_0203, 32'h0000_00A5);
        checks++; if (mem_wstrb !== 4'b1000 || mem_wdata !== 32'hA5A5_A5A5 || mem_addr !== 32'h200) begin errors++; $display("FAIL sb_lane got %b %h %h exp 1000 a5a5a5a5 00000200", mem_wstrb, mem_wdata, mem_addr); end
        // Stall one cycle with a competing request that must be ignored.
        lsu_valid = 1'b1; lsu_addr = 32'h0000_0F00; lsu_funct3 = 3'd2;
        step();
        lsu_valid = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h200 || mem_wstrb !== 4'b1000) begin errors++; $display("FAIL sb_stable got %b %h %b exp 1 00000200 1000", mem_req, mem_addr, mem_wstrb); end
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        checks++; if (lsu_done !== 1'b1) begin errors++; $display("FAIL sb_done got %b exp 1", lsu_done); end
        step();
        checks++; if (mem_req !== 1'b0 || lsu_ready !== 1'b1) begin errors++; $display("FAIL sb_no_second got %b%b exp 01", mem_req, lsu_ready); end
        issue(1'b1, 3'd1, 32'h0000_0102, 32'hFFFF_1234);
        checks++; if (mem_wstrb !== 4'b1100 || mem_wdata !== 32'h1234_1234 || mem_addr !== 32'h100) begin errors++; $display("FAIL sh_lane got %b %h %h exp 1100 12341234 00000100", mem_wstrb, mem_wdata, mem_addr); end
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        step();
    endtask

    task automatic test_load_ext();
        logic [31:0] rd, a_s;
        logic [3:0]  s_s;
        logic        e;
        int          lat;
        load_txn(3'd0, 32'h302, 32'h1280_FF34, rd, e, lat, a_s, s_s);
        checks++; if (rd !== 32'hFFFF_FF80 || e !== 1'b0) begin errors++; $display("FAIL lb got %h %b exp ffffff80 0", rd, e); end
        checks++; if (lat != 3) begin errors++; $display("FAIL load_latency got %0d exp 3", lat); end
        checks++; if (a_s !== 32'h300 || s_s !== 4'h0) begin errors++; $display("FAIL load_bus got %h %h exp 00000300 0", a_s, s_s); end
        checks++; if (lsu_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL rdata_hold got %h exp ffffff80", lsu_rdata); end
        load_txn(3'd4, 32'h302, 32'h1280_FF34, rd, e, lat, a_s, s_s);
        checks++; if (rd !== 32'h0000_0080) begin errors++; $display("FAIL lbu got %h exp 00000080", rd); end
        load_txn(3'd5, 32'h302, 32'h1280_FF34, rd, e, lat, a_s, s_s);
        checks++; if (rd !== 32'h0000_1280) begin errors++; $display("FAIL lhu got %h exp 00001280", rd); end
        load_txn(3'd1, 32'h300, 32'h1280_FF34, rd, e, lat, a_s, s_s);
        checks++; if (rd !== 32'hFFFF_FF34) begin errors++; $display("FAIL lh got %h exp ffffff34", rd); end
        load_txn(3'd0, 32'h301, 32'h1280_FF34, rd, e, lat, a_s, s_s);
        checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL lb_lane1 got %h exp ffffffff", rd); end
        load_txn(3'd2, 32'h308, 32'h1280_FF34, rd, e, lat, a_s, s_s);
        checks++; if (rd !== 32'h1280_FF34 || a_s !== 32'h308) begin errors++; $display("FAIL lw got %h %h exp 1280ff34 00000308", rd, a_s); end
    endtask

    task automatic test_timeout();
        int n;
        issue(1'b0, 3'd2, 32'h400, 32'h0);
        n = 0;
        while (mem_req && n < 20) begin
            n++;
            step();
        end
        checks++; if (n != 4) begin errors++; $display("FAIL timeout_req_cycles got %0d exp 4", n); end
        checks++; if (lsu_done !== 1'b1 || lsu_err !== 1'b1 || lsu_rdata !== 32'h0) begin errors++; $display("FAIL timeout_done got %b %b %h exp 1 1 0", lsu_done, lsu_err, lsu_rdata); end
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
        step();
        mem_rvalid = 1'b0;
        step();
        checks++; if (lsu_done !== 1'b0 || lsu_ready !== 1'b1 || lsu_rdata !== 32'h0) begin errors++; $display("FAIL stale_rvalid got %b %b %h exp 0 1 0", lsu_done, lsu_ready, lsu_rdata); end
    endtask

    task automatic test_illegal();
        issue(1'b0, 3'd3, 32'h500, 32'h0);
        checks++; if (lsu_done !== 1'b1 || lsu_err !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL illegal_load got %b %b %b exp 1 1 0", lsu_done, lsu_err, mem_req); end
        step();
        checks++; if (mem_req !== 1'b0 || lsu_done !== 1'b0) begin errors++; $display("FAIL illegal_load_after got %b %b exp 0 0", mem_req, lsu_done); end
        issue(1'b1, 3'd4, 32'h500, 32'h0);
        checks++; if (lsu_done !== 1'b1 || lsu_err !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL illegal_store got %b %b %b exp 1 1 0", lsu_done, lsu_err, mem_req); end
        step();
    endtask

    task automatic test_misalign();
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, 3'd1, 32'h101, 32'h0);
        checks++; if (lsu_done !== 1'b1 || lsu_err !== 1'b1 || mem_req !== 1'b0 || lsu_rdata !== 32'h0) begin errors++; $display("FAIL misalign_trap got %b %b %b %h exp 1 1 0 0", lsu_done, lsu_err, mem_req, lsu_rdata); end
        step();
`else
        logic [31:0] rd, a_s;
        logic [3:0]  s_s;
        logic        e;
        int          lat;
        load_txn(3'd1, 32'h101, 32'hAABB_CCDD, rd, e, lat, a_s, s_s);
        checks++; if (a_s !== 32'h100 || rd !== 32'hFFFF_CCDD || e !== 1'b0) begin errors++; $display("FAIL misalign_lh got %h %h %b exp 00000100 ffffccdd 0", a_s, rd, e); end
`endif
    endtask

    task automatic test_reset_mid();
        int dones;
        issue(1'b0, 3'd2, 32'h600, 32'h0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        rst_n = 1'b0;
        step();
        checks++; if (mem_req !== 1'b0 || lsu_ready !== 1'b1 || lsu_done !== 1'b0) begin errors++; $display("FAIL reset_mid got %b %b %b exp 0 1 0", mem_req, lsu_ready, lsu_done); end
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
        dones = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            mem_rvalid = 1'b0;
            if (lsu_done) dones++;
        end
        checks++; if (dones != 0 || lsu_rdata !== 32'h0) begin errors++; $display("FAIL reset_mid_nodone got %0d %h exp 0 0", dones, lsu_rdata); end
    endtask

    initial begin
        rst_n = 1'b0; lsu_valid = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'd0;
        lsu_addr = 32'h0; lsu_wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        test_reset();
        test_store_word();
        test_store_lanes();
        test_load_ext();
        test_timeout();
        test_illegal();
        test_misalign();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
